// File: rtl/cmp_pkg.sv
// Shared types and helpers for the stream max/min finder: FSM states,
// the debug view of the sequencer, and the index-width rule.
package cmp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRST   = 3'd1,
        CMP_MAX = 3'd2,
        CMP_MIN = 3'd3,
        HOLD    = 3'd4
    } state_e;

    // Current state plus the raw comparator flags, for checkers to bind on.
    typedef struct packed {
        state_e state;
        logic   gt;
        logic   eq;
        logic   lt;
    } dbg_t;

    function automatic int idx_width(input int frame_len);
        int w;
        w = $clog2(frame_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator; purely combinational.
module mag_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/stream_max_min_finder.sv
// Finds max/min (and first-occurrence index) of a FRAME_LEN-sample frame by
// time-sharing one comparator between the running-max and running-min checks.
module stream_max_min_finder
    import cmp_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int FRAME_LEN = 8,
    localparam int IDX_W     = idx_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_min_idx,
    input  logic             out_ack,
    output dbg_t             dbg_o
);

    // Handshakes: a sample moves when in_valid && in_ready in the same cycle;
    // a result is held with out_valid high until out_ack is seen in HOLD.

    localparam logic [8:0] LAST_CNT = 9'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;

    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             cmp_gt, cmp_eq, cmp_lt;
    logic             xfer;

    // The comparator operands follow the phase: new sample vs max, then min vs held sample.
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        case (state_q)
            CMP_MAX: begin cmp_a = in_data; cmp_b = max_q; end
            CMP_MIN: begin cmp_a = min_q;   cmp_b = cur_q; end
            default: ;
        endcase
    end

    mag_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    assign in_ready  = (state_q == FIRST) || (state_q == CMP_MAX);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);
    assign xfer      = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        min_d     = min_q;
        cur_d     = cur_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FIRST;
            end
            FIRST: begin
                if (xfer) begin
                    max_d     = in_data;
                    min_d     = in_data;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    cnt_d     = 9'd1;
                    state_d   = (FRAME_LEN == 1) ? HOLD : CMP_MAX;
                end
            end
            CMP_MAX: begin
                if (xfer) begin
                    cur_d = in_data;
                    if (cmp_gt) begin
                        max_d     = in_data;
                        max_idx_d = cnt_q[IDX_W-1:0];
                    end
                    state_d = CMP_MIN;
                end
            end
            CMP_MIN: begin
                // Strict compare: ties keep the earlier index.
                if (cmp_gt) begin
                    min_d     = cur_q;
                    min_idx_d = cnt_q[IDX_W-1:0];
                end
                cnt_d   = cnt_q + 9'd1;
                state_d = (cnt_q == LAST_CNT) ? HOLD : CMP_MAX;
            end
            HOLD: begin
                if (out_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            cur_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            cur_q     <= cur_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = max_idx_q;
    assign out_min_idx = min_idx_q;
    assign dbg_o       = {state_q, cmp_gt, cmp_eq, cmp_lt};

endmodule
